// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants for the UART receiver peripheral.
// Holds the bus register map, FSM state encodings, STATUS bit positions
// and bit-timing constants.
package uart_rx_pkg;

    // Bus register map (byte addresses)
    localparam logic [31:0] ADDR_RXDATA = 32'h4000_0018;
    localparam logic [31:0] ADDR_STATUS = 32'h4000_001C;
    localparam logic [31:0] ADDR_CTRL   = 32'h4000_0020;

    // Receiver FSM state encoding
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t S_IDLE   = 3'd0;
    localparam rx_state_t S_START  = 3'd1;
    localparam rx_state_t S_DATA   = 3'd2;
    localparam rx_state_t S_PARITY = 3'd3;
    localparam rx_state_t S_STOP   = 3'd4;

    // STATUS register bit positions
    localparam int STAT_NONEMPTY   = 0;
    localparam int STAT_FULL       = 1;
    localparam int STAT_FRAME_ERR  = 2;
    localparam int STAT_OVERRUN    = 3;
    localparam int STAT_PARITY_ERR = 4;

    // Bit timing: 16 oversampling ticks per bit, sample on tick count 7
    localparam logic [3:0] MID_TICK      = 4'd7;
    localparam int         TICKS_PER_BIT = 16;

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous FIFO buffering received characters.
// Pointers carry one extra wrap bit so full/empty come straight from a
// pointer comparison. A push while full is accepted if a pop frees a slot
// in the same cycle; a pop while empty is ignored.
module rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; empty pointers keep stale entries from ever being observed.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: memory-mapped UART receiver (8N1, 16x oversampling).
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds
// a PARITY state plus STATUS.parity_err.
module uart_rx_unit
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int DIV   = CLK_FREQ / (BAUD * TICKS_PER_BIT);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [DIV_W-1:0] div_q, div_d;
    rx_state_t        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             ie_q, ie_d;
    logic             par_err_q, par_err_d;
    logic             par_bad_q, par_bad_d;

    logic       tick, mid, push_req, pop, set_frame_err, set_parity_err, set_overrun;
    logic       wr_status;
    logic [7:0] fifo_dout;
    logic       fifo_full, fifo_empty;
    logic       unused_wdata;

    assign tick        = (div_q == DIV_W'(DIV - 1));
    assign mid         = tick && (cnt_q == MID_TICK);
    assign pop         = rd && (addr == ADDR_RXDATA);
    assign set_overrun = push_req && fifo_full && !pop;
    assign wr_status   = wr && (addr == ADDR_STATUS);
    assign irq         = ie_q && !fifo_empty;

    rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (shift_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Synchronizer stages and free-running oversampling tick divider
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        div_d     = tick ? '0 : div_q + DIV_W'(1);
    end

    // Frame deserializer: start validation, data shift-in, parity, stop check
    always_comb begin
        state_d        = state_q;
        cnt_d          = tick ? cnt_q + 4'd1 : cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        par_bad_d      = par_bad_q;
        push_req       = 1'b0;
        set_frame_err  = 1'b0;
        set_parity_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (mid) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;          // too short to be a start bit
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid) begin
                    par_bad_d      = ^{shift_q, rx_s_q};
                    set_parity_err = ^{shift_q, rx_s_q};
                    state_d        = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid) begin
                    state_d = S_IDLE;              // leave early so a following start edge is caught
                    if (!rx_s_q)         set_frame_err = 1'b1;
                    else if (!par_bad_q) push_req      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky error flags (set beats W1C clear) and interrupt enable
    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        par_err_d   = par_err_q;
        ie_d        = ie_q;
        if (wr_status && wdata[STAT_FRAME_ERR]) frame_err_d = 1'b0;
        if (wr_status && wdata[STAT_OVERRUN])   overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        if (wr_status && wdata[STAT_PARITY_ERR]) par_err_d  = 1'b0;
        if (set_parity_err)                      par_err_d  = 1'b1;
`endif
        if (set_frame_err) frame_err_d = 1'b1;
        if (set_overrun)   overrun_d   = 1'b1;
        if (wr && (addr == ADDR_CTRL)) ie_d = wdata[0];
    end

`ifdef UART_RX_PARITY_EN
    assign unused_wdata = ^{wdata[31:5], wdata[1]};
`else
    assign unused_wdata = ^{wdata[31:4], wdata[1], set_parity_err};
`endif

    // Register read mux; zero whenever no register is being read
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                ADDR_RXDATA: if (!fifo_empty) rdata = {24'b0, fifo_dout};
                ADDR_STATUS: begin
                    rdata[STAT_NONEMPTY]   = !fifo_empty;
                    rdata[STAT_FULL]       = fifo_full;
                    rdata[STAT_FRAME_ERR]  = frame_err_q;
                    rdata[STAT_OVERRUN]    = overrun_q;
                    rdata[STAT_PARITY_ERR] = par_err_q;
                end
                ADDR_CTRL:   rdata[0] = ie_q;
                default:     rdata = '0;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            div_q       <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            ie_q        <= 1'b0;
            par_err_q   <= 1'b0;
            par_bad_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            div_q       <= div_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            ie_q        <= ie_d;
            par_err_q   <= par_err_d;
            par_bad_q   <= par_bad_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: scoreboard bench for uart_rx_unit.
// Reads push their expected rdata/irq into queues; a monitor compares
// whenever a bus read is on the bus. A fast baud (DIV = 4, 64 clk/bit)
// keeps the serial stimulus short.
module tb_uart_rx_unit;
    localparam int CLK_FREQ = 10_000_000;
    localparam int BAUD     = 156_250;
    localparam int BIT_CLKS = 16 * (CLK_FREQ / (BAUD * 16));

    localparam logic [31:0] A_RXDATA = 32'h4000_0018;
    localparam logic [31:0] A_STATUS = 32'h4000_001C;
    localparam logic [31:0] A_CTRL   = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_data_q[$];
    logic        exp_irq_q[$];
    string       exp_name_q[$];

    uart_rx_unit #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: compare every bus read against the oldest expectation
    initial begin
        string       nm;
        logic [31:0] ed;
        logic        ei;
        forever begin
            @(negedge clk);
            #2;
            if (rd) begin
                if (exp_data_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_read: addr 0x%08h with no expectation queued", addr);
                end else begin
                    nm = exp_name_q.pop_front();
                    ed = exp_data_q.pop_front();
                    ei = exp_irq_q.pop_front();
                    check({nm, "_rdata"}, rdata, ed);
                    check({nm, "_irq"}, {31'b0, irq}, {31'b0, ei});
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input logic [31:0] exp, input logic exp_irq, input string name);
        exp_data_q.push_back(exp);
        exp_irq_q.push_back(exp_irq);
        exp_name_q.push_back(name);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp,
                            input logic exp_irq, input string name);
        wait_clks(1);
        expect_read(exp, exp_irq, name);
        rd   = 1'b1;
        addr = a;
        wait_clks(1);
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wait_clks(1);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        wait_clks(1);
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    // One frame; a bad stop bit is held low past mid-bit, then the line idles
    task automatic send_frame(input logic [7:0] data, input logic stop_ok);
        wait_clks(1);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end else begin
            rx = 1'b0;
            wait_clks(40);
            rx = 1'b1;
            wait_clks(BIT_CLKS - 40);
        end
    endtask

    initial begin
        bit seen;

        // Reset state
        bus_read(A_STATUS, 32'h0, 1'b0, "reset_status");
        bus_read(A_RXDATA, 32'h0, 1'b0, "reset_rxdata");
        bus_read(A_CTRL,   32'h0, 1'b0, "reset_ctrl");
        wait_clks(1);
        reset = 1'b1;
        wait_clks(200);
        bus_read(A_STATUS, 32'h0, 1'b0, "idle_status");

        // Enable interrupt, receive 0xA5
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, 32'h1, 1'b0, "ctrl_ie");
        send_frame(8'hA5, 1'b1);
        wait_clks(4);
        bus_read(A_STATUS, 32'h1, 1'b1, "a5_status");
        bus_read(A_RXDATA, 32'hA5, 1'b1, "a5_rxdata");
        bus_read(A_STATUS, 32'h0, 1'b0, "a5_drained");

        // Quarter-bit glitch must not start a frame
        wait_clks(1);
        rx = 1'b0;
        wait_clks(BIT_CLKS / 4);
        rx = 1'b1;
        wait_clks(3 * BIT_CLKS);
        bus_read(A_STATUS, 32'h0, 1'b0, "glitch_status");

        // Framing error on 0x3C, then W1C
        send_frame(8'h3C, 1'b0);
        wait_clks(2 * BIT_CLKS);
        bus_read(A_STATUS, 32'h4, 1'b0, "ferr_status");
        bus_read(A_RXDATA, 32'h0, 1'b0, "ferr_rxdata");
        bus_write(A_STATUS, 32'h4);
        bus_read(A_STATUS, 32'h0, 1'b0, "ferr_cleared");

        // Nine back-to-back bytes overflow the eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        wait_clks(8);
        bus_read(A_STATUS, 32'hB, 1'b1, "ovr_status");
        for (int i = 1; i <= 8; i++) bus_read(A_RXDATA, 32'(i), 1'b1, $sformatf("ovr_rd%0d", i));
        bus_read(A_STATUS, 32'h8, 1'b0, "ovr_after_drain");
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, 32'h0, 1'b0, "ovr_cleared");

        // Fill to eight, then pop on the very edge the ninth byte is pushed
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
        seen = 1'b0;
        fork
            send_frame(8'h18, 1'b1);
            begin
                for (int i = 0; i < 12 * BIT_CLKS && !seen; i++) begin
                    @(negedge clk);
                    if (dut.push_req) seen = 1'b1;
                end
                if (seen) begin
                    #1;
                    expect_read(32'h10, 1'b1, "coinc_rxdata");
                    rd   = 1'b1;
                    addr = A_RXDATA;
                    @(posedge clk);
                    #1;
                    rd   = 1'b0;
                    addr = '0;
                end else begin
                    n_checks++;
                    $display("FAIL coinc_push_timeout: no push seen within %0d clks", 12 * BIT_CLKS);
                end
            end
        join
        wait_clks(8);
        bus_read(A_STATUS, 32'h3, 1'b1, "coinc_status");
        for (int i = 1; i <= 8; i++)
            bus_read(A_RXDATA, 32'h10 + 32'(i), 1'b1, $sformatf("coinc_rd%0d", i));
        bus_read(A_STATUS, 32'h0, 1'b0, "coinc_drained");

        // Every queued expectation must have been consumed
        wait_clks(10);
        check("scoreboard_empty", 32'(exp_data_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
